// File: rtl/exec_stage.sv
// exec_stage: multi-cycle RV32I subset execute core (ADD SUB AND OR XOR SLT
// ADDI LUI LW SW BEQ BNE JAL) sequenced FETCH -> WAIT_I -> EXEC [-> WAIT_M].
// Unsupported encodings and misaligned data/jump addresses stop the core in
// HALT until reset.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   Instr        in   fetched instruction, taken in WAIT_I on Instr_valid
//   Instr_valid  in   fetch-complete pulse
//   Mem_rdata    in   load data, taken in WAIT_M on Mem_valid
//   Mem_valid    in   data-access-complete pulse
//   Next_PC      out  fetch address
//   Fetch_req    out  fetch request pulse (FETCH state)
//   Data_addr    out  load/store byte address
//   Data_wdata   out  store data
//   S            out  1=store / 0=load while Mem_req=1
//   Mem_req      out  data request pulse (EXEC state, LW/SW)
//   Halt         out  sticky halt indicator
//   Instret      out  retired-instruction counter (EXEC_STAGE_INSTRET_EN only)
//
// Optional feature macro: EXEC_STAGE_INSTRET_EN
module exec_stage (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Instr_valid,
  input  logic [31:0] Mem_rdata,
  input  logic        Mem_valid,
  output logic [31:0] Next_PC,
  output logic        Fetch_req,
  output logic [31:0] Data_addr,
  output logic [31:0] Data_wdata,
  output logic        S,
  output logic        Mem_req,
  output logic        Halt
`ifdef EXEC_STAGE_INSTRET_EN
  ,
  output logic [31:0] Instret
`endif
);

  typedef enum logic [2:0] {FETCH, WAIT_I, EXEC, WAIT_M, HALT} state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, r_ir, r_daddr, r_dwdata;
  logic        r_s;
  logic [31:0] r_regs [32];

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_a, w_b, w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [31:0] w_addr, w_pc4, w_tgt, w_res, w_pc_nx, w_wdata;
  logic        w_ok, w_wr, w_take, w_we, w_mem_go, w_is_store, w_retire;

  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_a = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_b = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};

  assign w_addr = w_a + ((w_op == OP_ST) ? w_imm_s : w_imm_i);
  assign w_pc4  = r_pc + 32'd4;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_we       = 1'b0;
    w_wdata    = '0;
    w_mem_go   = 1'b0;
    w_is_store = 1'b0;
    w_retire   = 1'b0;
    w_ok       = 1'b0;
    w_wr       = 1'b0;
    w_take     = 1'b0;
    w_tgt      = w_pc4;
    w_res      = '0;
    case (r_state)
      FETCH:  w_state_nx = WAIT_I;
      WAIT_I: if (Instr_valid) w_state_nx = EXEC;
      EXEC: begin
        // Anything not explicitly accepted below falls through to HALT.
        w_state_nx = HALT;
        case (w_op)
          OP_R: begin
            w_ok = 1'b1;
            w_wr = 1'b1;
            case ({w_f7, w_f3})
              10'b0000000_000: w_res = w_a + w_b;
              10'b0100000_000: w_res = w_a - w_b;
              10'b0000000_111: w_res = w_a & w_b;
              10'b0000000_110: w_res = w_a | w_b;
              10'b0000000_100: w_res = w_a ^ w_b;
              10'b0000000_010: w_res = {31'b0, $signed(w_a) < $signed(w_b)};
              default: begin
                w_ok = 1'b0;
                w_wr = 1'b0;
              end
            endcase
          end
          OP_I: if (w_f3 == 3'b000) begin
            w_ok  = 1'b1;
            w_wr  = 1'b1;
            w_res = w_a + w_imm_i;
          end
          OP_LUI: begin
            w_ok  = 1'b1;
            w_wr  = 1'b1;
            w_res = w_imm_u;
          end
          OP_JAL: begin
            w_take = 1'b1;
            w_tgt  = r_pc + w_imm_j;
            w_ok   = (w_tgt[1:0] == 2'b00);
            w_wr   = 1'b1;
            w_res  = w_pc4;
          end
          OP_BR: if (w_f3[2:1] == 2'b00) begin
            // f3=000 BEQ, f3=001 BNE: taken when equality differs from f3[0]
            w_take = (w_a == w_b) ^ w_f3[0];
            w_tgt  = r_pc + w_imm_b;
            w_ok   = !w_take || (w_tgt[1:0] == 2'b00);
          end
          OP_LD, OP_ST: if (w_f3 == 3'b010 && w_addr[1:0] == 2'b00) begin
            w_mem_go   = 1'b1;
            w_is_store = (w_op == OP_ST);
            w_state_nx = WAIT_M;
          end
          default: ;
        endcase
        if (w_ok) begin
          w_state_nx = FETCH;
          w_retire   = 1'b1;
          w_pc_nx    = w_take ? w_tgt : w_pc4;
          w_we       = w_wr;
          w_wdata    = w_res;
        end
      end
      WAIT_M: if (Mem_valid) begin
        w_state_nx = FETCH;
        w_pc_nx    = w_pc4;
        w_retire   = 1'b1;
        w_we       = !r_s;
        w_wdata    = Mem_rdata;
      end
      HALT: ;
      default: w_state_nx = HALT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_s      <= 1'b0;
      r_regs   <= '{default: '0};
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      if (r_state == WAIT_I && Instr_valid) r_ir <= Instr;
      if (w_mem_go) begin
        r_daddr  <= w_addr;
        r_dwdata <= w_b;
        r_s      <= w_is_store;
      end
      if (w_we && w_rd != 5'd0) r_regs[w_rd] <= w_wdata;
    end
  end

`ifdef EXEC_STAGE_INSTRET_EN
  logic [31:0] r_instret;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end
  assign Instret = r_instret;
`endif

  // State is FETCH while reset is held, so gate the request with reset to
  // keep it low until release.
  assign Fetch_req  = (r_state == FETCH) && Reset;
  assign Mem_req    = w_mem_go;
  // Address/data/direction are live in the request cycle and then held.
  assign Data_addr  = w_mem_go ? w_addr : r_daddr;
  assign Data_wdata = w_mem_go ? w_b : r_dwdata;
  assign S          = w_mem_go ? w_is_store : r_s;
  assign Next_PC    = r_pc;
  assign Halt       = (r_state == HALT);

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit data/address, 32 x 32-bit register file).
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset, asynchronous and active-low.
REQ-004 Instr  input  32  fetched instruction word, sampled only in WAIT_I when Instr_valid=1.
REQ-005 Instr_valid  input  1  one-cycle pulse, Instr holds the word fetched from Next_PC.
REQ-006 Mem_rdata  input  32  load data, sampled only in WAIT_M when Mem_valid=1.
REQ-007 Mem_valid  input  1  one-cycle pulse, data access complete.
REQ-008 Next_PC  output  32  address of the instruction to fetch.
REQ-009 Fetch_req  output  1  one-cycle pulse requesting a fetch at Next_PC.
REQ-010 Data_addr  output  32  load/store byte address.
REQ-011 Data_wdata  output  32  store data.
REQ-012 S  output  1  1=store, 0=load, meaningful while Mem_req=1.
REQ-013 Mem_req  output  1  one-cycle pulse requesting a data access.
REQ-014 Halt  output  1  sticky halt indicator.

Function
REQ-015 States SHALL be FETCH, WAIT_I, EXEC, WAIT_M, HALT; FETCH->WAIT_I unconditionally; WAIT_I->EXEC on Instr_valid; WAIT_M->FETCH on Mem_valid; HALT is terminal until reset.
REQ-016 In FETCH, Fetch_req SHALL be 1 for exactly that cycle; Next_PC SHALL be stable from FETCH until the next EXEC completes.
REQ-017 Supported opcodes SHALL be ADD, SUB, AND, OR, XOR, SLT (signed), ADDI, LUI, LW, SW, BEQ, BNE, JAL (RV32I encodings); any other opcode/funct SHALL enter HALT.
REQ-018 EXEC SHALL take exactly one cycle: ALU ops, LUI and JAL write rd and go to FETCH; LW/SW go to WAIT_M with Mem_req=1, Data_addr=rs1+sext(imm), S and Data_wdata=rs2 driven in the same cycle.
REQ-019 LW SHALL write Mem_rdata to rd on the Mem_valid cycle; SW SHALL write no register.
REQ-020 Next_PC SHALL update at end of EXEC (non-memory) or WAIT_M completion: PC+4, or PC+sext(imm) for taken BEQ/BNE and JAL; JAL writes PC+4 to rd.
REQ-021 All address/ALU arithmetic SHALL wrap modulo 2^32; immediates sign-extended to 32 bits.
REQ-022 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-023 LW/SW with Data_addr[1:0]!=0 or taken branch/JAL target with [1:0]!=0 SHALL enter HALT with no memory request and no register write.
REQ-024 Instr_valid outside WAIT_I and Mem_valid outside WAIT_M SHALL be ignored.
REQ-025 Instr_valid and Mem_valid asserted together SHALL act only on the one matching the current state.
REQ-026 Halt=1 in HALT; Fetch_req and Mem_req SHALL stay 0 in HALT.

Reset
REQ-027 Reset=0 SHALL immediately force state FETCH, Next_PC=0, Data_addr=0, Data_wdata=0, S=0, Fetch_req=0, Mem_req=0, Halt=0, all registers 0, regardless of current state.
REQ-028 The first Fetch_req SHALL assert in the first cycle after Reset deasserts; an outstanding fetch/access cut by reset SHALL be abandoned and its late valid pulse ignored.

Configuration
REQ-029 With macro EXEC_STAGE_INSTRET_EN defined, the block SHALL add output Instret (32 bits), reset to 0, incrementing (wrapping) once per retired instruction: end of EXEC for non-memory ops, Mem_valid cycle for LW/SW; halting instructions are not counted.
REQ-030 Without EXEC_STAGE_INSTRET_EN the Instret port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Release reset -> Fetch_req=1 with Next_PC=0 in first cycle; ADDI x1,x0,5 delivered -> x1=5, next Fetch_req at Next_PC=4.
REQ-032 x1=8, SW x1,4(x0) then LW x2,4(x0) with Mem_rdata=8 -> Mem_req pulses with S=1/Data_addr=4/Data_wdata=8, then S=0/Data_addr=4; x2=8.
REQ-033 x1=x2=3 at PC=0x10, BEQ x1,x2,-16 -> Next_PC=0x0; BNE same operands -> Next_PC=0x14.
REQ-034 LW x3,2(x0) -> Halt=1, no Mem_req, x3 unchanged; stray Instr_valid pulses stay ignored.
REQ-035 Assert Reset in WAIT_M, then deliver the late Mem_valid after release -> ignored, Next_PC=0, registers 0.
REQ-036 With EXEC_STAGE_INSTRET_EN, run ADDI, SW, illegal opcode -> Instret=2, Halt=1.
